// File: rtl/video_pixel_shifter_if.sv
// Fetch-side and pixel-side signals of the video pixel shifter.
// The shifter takes the slave modport; whatever drives it takes the master modport.
interface video_pixel_shifter_if;
  logic        load;
  logic [31:0] fetch_data;
  logic [1:0]  vmode;
  logic [3:0]  palsel;
  logic        flash;
  logic [7:0]  border;
  logic        pix_stb;
  logic        flush;
  logic [7:0]  pix_idx;
  logic        pix_vld;
  logic        need_data;
  logic        overrun;

  modport master (
    output load, fetch_data, vmode, palsel, flash, border, pix_stb, flush,
    input  pix_idx, pix_vld, need_data, overrun
  );

  modport slave (
    input  load, fetch_data, vmode, palsel, flash, border, pix_stb, flush,
    output pix_idx, pix_vld, need_data, overrun
  );
endinterface

// File: rtl/video_pixel_shifter.sv
// Serialises fetched 32-bit video words into 8-bit palette indices (ZX, 16c, 256c, blank),
// with a one-word holding register so consecutive words stream without border gaps.
module video_pixel_shifter #(
  parameter logic [7:0] BORDER_DEF = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  video_pixel_shifter_if.slave  vif
);

  logic [31:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [31:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  pal_q, pal_d;
  logic [7:0]  pix_idx_q, pix_idx_d;
  logic        pix_vld_q, pix_vld_d;
  logic        overrun_q, overrun_d;

  logic        xfer;
  logic        emit;
  logic [2:0]  bsel;
  logic [7:0]  zx_pix;
  logic [7:0]  zx_attr;
  logic        zx_ink;
  logic [2:0]  zx_col;
  logic [7:0]  pix_new;
  logic [31:0] sr_next;
  logic [4:0]  word_len;

  always_comb begin
    xfer = hold_full_q && ((cnt_q == 5'd0) || ((cnt_q == 5'd1) && vif.pix_stb));
    emit = vif.pix_stb && (cnt_q != 5'd0);

    // ZX: bit 7 of the pixel byte goes first; cnt counts 8..1 within each byte.
    bsel    = cnt_q[2:0] - 3'd1;
    zx_pix  = sr_q[7:0];
    zx_attr = sr_q[15:8];
    zx_ink  = zx_pix[bsel] ^ (zx_attr[7] & vif.flash);
    zx_col  = zx_ink ? zx_attr[2:0] : zx_attr[5:3];

    case (mode_q)
      2'd0: begin
        pix_new = {pal_q, zx_attr[6], zx_col};
        sr_next = (cnt_q[2:0] == 3'd1) ? {16'h0000, sr_q[31:16]} : sr_q;
      end
      2'd1: begin
        // High nibble first (even count), then low nibble and move to the next byte.
        pix_new = {pal_q, (cnt_q[0] ? sr_q[3:0] : sr_q[7:4])};
        sr_next = cnt_q[0] ? {8'h00, sr_q[31:8]} : sr_q;
      end
      2'd2: begin
        pix_new = sr_q[7:0];
        sr_next = {8'h00, sr_q[31:8]};
      end
      default: begin
        pix_new = 8'h00;
        sr_next = {8'h00, sr_q[31:8]};
      end
    endcase

    case (vif.vmode)
      2'd0:    word_len = 5'd16;
      2'd1:    word_len = 5'd8;
      default: word_len = 5'd4;
    endcase

    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    pal_d       = pal_q;
    pix_idx_d   = pix_idx_q;
    pix_vld_d   = pix_vld_q;
    overrun_d   = overrun_q;

    if (vif.load) begin
      hold_d      = vif.fetch_data;
      hold_full_d = 1'b1;
      if (hold_full_q && !xfer) overrun_d = 1'b1;
    end

    if (vif.pix_stb) begin
      if (emit) begin
        pix_idx_d = pix_new;
        pix_vld_d = 1'b1;
        sr_d      = sr_next;
        cnt_d     = cnt_q - 5'd1;
      end else begin
        pix_idx_d = vif.border;
        pix_vld_d = 1'b0;
      end
    end

    // A transfer on the last-pixel cycle overrides the shift/decrement above.
    if (xfer) begin
      sr_d   = hold_q;
      mode_d = vif.vmode;
      pal_d  = vif.palsel;
      cnt_d  = word_len;
      if (!vif.load) hold_full_d = 1'b0;
    end

    if (vif.flush) begin
      hold_full_d = 1'b0;
      cnt_d       = 5'd0;
      overrun_d   = 1'b0;
      pix_idx_d   = vif.border;
      pix_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= 32'h0;
      hold_full_q <= 1'b0;
      sr_q        <= 32'h0;
      cnt_q       <= 5'd0;
      mode_q      <= 2'd0;
      pal_q       <= 4'h0;
      pix_idx_q   <= BORDER_DEF;
      pix_vld_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      pal_q       <= pal_d;
      pix_idx_q   <= pix_idx_d;
      pix_vld_q   <= pix_vld_d;
      overrun_q   <= overrun_d;
    end
  end

  assign vif.pix_idx   = pix_idx_q;
  assign vif.pix_vld   = pix_vld_q;
  assign vif.need_data = ~hold_full_q;
  assign vif.overrun   = overrun_q;

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Directed, table-driven bench for video_pixel_shifter: one vector per clock cycle,
// plus a hand-written asynchronous-reset-mid-word sequence.
module tb_video_pixel_shifter;

  localparam logic [7:0] BDEF = 8'hE7;
  localparam logic [7:0] BRD  = 8'h3C;

  logic clk;
  logic rst_n;
  video_pixel_shifter_if vif ();

  video_pixel_shifter #(.BORDER_DEF(BDEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [31:0] data;
    logic [1:0]  mode;
    logic [3:0]  pal;
    logic        fl;
    logic        stb;
    logic        flsh;
    logic [7:0]  e_idx;
    logic        e_vld;
    logic        e_need;
    logic        e_ovr;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic v(input logic ld, input logic [31:0] data, input logic [1:0] mode,
                   input logic [3:0] pal, input logic fl, input logic stb, input logic flsh,
                   input logic [7:0] e_idx, input logic e_vld, input logic e_need,
                   input logic e_ovr);
    vec_t t;
    t.ld = ld; t.data = data; t.mode = mode; t.pal = pal; t.fl = fl; t.stb = stb;
    t.flsh = flsh; t.e_idx = e_idx; t.e_vld = e_vld; t.e_need = e_need; t.e_ovr = e_ovr;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] idx, input logic vld,
                         input logic need, input logic ovr);
    chk({tag, " pix_idx"},   {24'h0, vif.pix_idx},  {24'h0, idx});
    chk({tag, " pix_vld"},   {31'h0, vif.pix_vld},  {31'h0, vld});
    chk({tag, " need_data"}, {31'h0, vif.need_data}, {31'h0, need});
    chk({tag, " overrun"},   {31'h0, vif.overrun},  {31'h0, ovr});
  endtask

  task automatic drive_idle();
    vif.load = 1'b0; vif.fetch_data = 32'h0; vif.vmode = 2'd2; vif.palsel = 4'h0;
    vif.flash = 1'b0; vif.pix_stb = 1'b0; vif.flush = 1'b0;
  endtask

  initial begin
    logic [7:0] e16c [8];
    logic [7:0] ezx0 [16];
    logic [7:0] ezx1 [16];
    e16c = '{8'h52, 8'h51, 8'h54, 8'h53, 8'h56, 8'h55, 8'h58, 8'h57};
    ezx0 = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h08, 8'h08, 8'h08, 8'h08,
             8'h08, 8'h08, 8'h08, 8'h08, 8'h09, 8'h09, 8'h09, 8'h09};
    ezx1 = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h08, 8'h08, 8'h08, 8'h08,
             8'h09, 8'h09, 8'h09, 8'h09, 8'h08, 8'h08, 8'h08, 8'h08};

    // Idle border, then 256c word with continuous pix_stb (palsel must be ignored)
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, BRD,   0, 1, 0);
    v(1, 32'hDDCCBBAA, 2, 4'hF, 0, 1, 0, BRD,   0, 0, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, BRD,   0, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'hAA, 1, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'hBB, 1, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'hCC, 1, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'hDD, 1, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, BRD,   0, 1, 0);
    // 16c, palsel 5; outputs hold while pix_stb is low
    v(1, 32'h87654321, 1, 4'h5, 0, 0, 0, BRD,   0, 0, 0);
    v(0, 32'h0,        1, 4'h5, 0, 0, 0, BRD,   0, 1, 0);
    for (int i = 0; i < 8; i++) v(0, 32'h0, 1, 4'h5, 0, 1, 0, e16c[i], 1, 1, 0);
    v(0, 32'h0,        1, 4'h5, 0, 1, 0, BRD,   0, 1, 0);
    // ZX, flash 0 then flash 1
    v(1, 32'hC10F47F0, 0, 4'h0, 0, 0, 0, BRD,   0, 0, 0);
    v(0, 32'h0,        0, 4'h0, 0, 0, 0, BRD,   0, 1, 0);
    for (int i = 0; i < 16; i++) v(0, 32'h0, 0, 4'h0, 0, 1, 0, ezx0[i], 1, 1, 0);
    v(0, 32'h0,        0, 4'h0, 0, 1, 0, BRD,   0, 1, 0);
    v(1, 32'hC10F47F0, 0, 4'h0, 1, 0, 0, BRD,   0, 0, 0);
    v(0, 32'h0,        0, 4'h0, 1, 0, 0, BRD,   0, 1, 0);
    for (int i = 0; i < 16; i++) v(0, 32'h0, 0, 4'h0, 1, 1, 0, ezx1[i], 1, 1, 0);
    v(0, 32'h0,        0, 4'h0, 1, 1, 0, BRD,   0, 1, 0);
    // Back-to-back 256c words, pix_stb every cycle
    v(1, 32'h03020100, 2, 4'hF, 0, 1, 0, BRD,   0, 0, 0);
    v(1, 32'h07060504, 2, 4'hF, 0, 1, 0, BRD,   0, 0, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h00, 1, 0, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h01, 1, 0, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h02, 1, 0, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h03, 1, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h04, 1, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h05, 1, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h06, 1, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h07, 1, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, BRD,   0, 1, 0);
    // Three loads without pix_stb: second word lost, third one output
    v(1, 32'h44332211, 2, 4'hF, 0, 0, 0, BRD,   0, 0, 0);
    v(1, 32'h88776655, 2, 4'hF, 0, 0, 0, BRD,   0, 0, 0);
    v(1, 32'hCCBBAA99, 2, 4'hF, 0, 0, 0, BRD,   0, 0, 1);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h11, 1, 0, 1);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h22, 1, 0, 1);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h33, 1, 0, 1);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h44, 1, 1, 1);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'h99, 1, 1, 1);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, 8'hAA, 1, 1, 1);
    // Flush mid-word wins over a simultaneous load and pix_stb
    v(1, 32'hDEADBEEF, 2, 4'hF, 0, 1, 1, BRD,   0, 1, 0);
    v(0, 32'h0,        2, 4'hF, 0, 1, 0, BRD,   0, 1, 0);
    // Blank mode: valid zero pixels
    v(1, 32'hFFFFFFFF, 3, 4'hF, 0, 0, 0, BRD,   0, 0, 0);
    v(0, 32'h0,        3, 4'hF, 0, 0, 0, BRD,   0, 1, 0);
    for (int i = 0; i < 4; i++) v(0, 32'h0, 3, 4'hF, 0, 1, 0, 8'h00, 1, 1, 0);
    v(0, 32'h0,        3, 4'hF, 0, 1, 0, BRD,   0, 1, 0);

    drive_idle();
    vif.border = BRD;
    rst_n = 1'b0;
    #23;
    chk_all("reset", BDEF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      vif.load = vecs[i].ld; vif.fetch_data = vecs[i].data; vif.vmode = vecs[i].mode;
      vif.palsel = vecs[i].pal; vif.flash = vecs[i].fl; vif.pix_stb = vecs[i].stb;
      vif.flush = vecs[i].flsh;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_idx, vecs[i].e_vld, vecs[i].e_need,
              vecs[i].e_ovr);
    end

    // Asynchronous reset in the middle of a 256c word
    @(negedge clk);
    drive_idle();
    vif.load = 1'b1; vif.fetch_data = 32'h5A6B7C8D;
    @(negedge clk);
    vif.load = 1'b0;
    @(negedge clk);
    vif.pix_stb = 1'b1;
    @(posedge clk);
    #1;
    chk_all("pre_rst", 8'h8D, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", BDEF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("post_rst%0d", i), BRD, 1'b0, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
